// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment scan display: digit index type,
// active-low hex segment patterns and the blank codes.
package disp_pkg;

  typedef logic [1:0] digit_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low [6:0] = g..a, entry i is the glyph for nibble value i.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PAT[nibble];

endmodule

// File: rtl/disp_number_scan.sv
// Four-digit common-anode seven-segment scanner with per-frame input shadowing.
// Optional leading-zero blanking is enabled by defining DISP_LEADING_ZERO_BLANK_EN.
module disp_number_scan
  import disp_pkg::*;
#(
  parameter int DIV_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT
);

  logic [DIV_W-1:0] cnt;
  logic [15:0]      hexs_sh;
  logic [3:0]       points_sh;
  logic [3:0]       les_sh;
  digit_t           sel;
  logic [3:0]       nib;
  logic [6:0]       pat;
  logic [3:0]       lz_dark;
  logic             dark;

  assign sel = cnt[DIV_W-1 -: 2];
  assign nib = hexs_sh[{sel, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nibble (nib),
    .seg    (pat)
  );

`ifdef DISP_LEADING_ZERO_BLANK_EN
  // A digit goes dark only when it and every more significant nibble are zero.
  always_comb begin
    lz_dark    = 4'b0000;
    lz_dark[3] = (hexs_sh[15:12] == 4'h0);
    lz_dark[2] = lz_dark[3] && (hexs_sh[11:8] == 4'h0);
    lz_dark[1] = lz_dark[2] && (hexs_sh[7:4] == 4'h0);
  end
`else
  assign lz_dark = 4'b0000;
`endif

  assign dark = les_sh[sel] | lz_dark[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hexs_sh   <= '0;
      points_sh <= '0;
      les_sh    <= '0;
      AN        <= AN_OFF;
      SEGMENT   <= SEG_OFF;
    end else begin
      cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      // Frame end: the next frame (starting at digit 0) uses these values.
      if (&cnt) begin
        hexs_sh   <= hexs;
        points_sh <= points;
        les_sh    <= les;
      end
      if (dark) begin
        AN      <= AN_OFF;
        SEGMENT <= SEG_OFF;
      end else begin
        AN      <= ~(4'b0001 << sel);
        SEGMENT <= {~points_sh[sel], pat};
      end
    end
  end

endmodule
